// File: rtl/sng_pkg.sv
// Shared types and constants for the stochastic-number-generator bank sequencer.
package sng_pkg;

    typedef enum logic [2:0] {IDLE, START, WAIT, STREAM, DONE, GAP} sng_seq_state_t;

    localparam int unsigned SNG_IN_W           = 4;
    localparam int unsigned STREAM_LEN_DEFAULT = 16;

endpackage

// File: rtl/sng_seq_timer.sv
// Loadable down-counter with a zero flag; times both the pipeline wait and the idle gap.
module sng_seq_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk_sng,
    input  logic             i_rst_sng,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; the count saturates at zero.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sng_bank_sequencer.sv
// Frames one operand vector through a lock-step SNG bank: start, pipeline wait,
// STREAM_LEN valid bit cycles, done/abort report and a recovery gap.
module sng_bank_sequencer
    import sng_pkg::*;
#(
    parameter int unsigned N_LANES    = 8,
    parameter int unsigned STREAM_LEN = STREAM_LEN_DEFAULT,
    parameter int unsigned PIPE_DLY   = 2,
    parameter int unsigned GAP_CYC    = 1,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic                            i_clk_sng,
    input  logic                            i_rst_sng,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [SNG_IN_W*N_LANES-1:0]     i_x_vec,
    input  logic                            i_abort,
    output logic [SNG_IN_W*N_LANES-1:0]     o_x_bn,
    output logic                            o_start,
    output logic                            o_stop,
    output logic                            o_bit_valid,
    output logic [$clog2(STREAM_LEN)-1:0]   o_bit_idx,
    output logic                            o_done,
    output logic                            o_aborted,
    output logic [FCNT_W-1:0]               o_frame_cnt
);

    localparam int unsigned X_W   = SNG_IN_W * N_LANES;
    localparam int unsigned IDX_W = $clog2(STREAM_LEN);
    localparam int unsigned T_MAX = (PIPE_DLY > GAP_CYC) ? PIPE_DLY : GAP_CYC;
    localparam int unsigned T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STREAM_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [T_W-1:0]    T_PIPE    = T_W'(PIPE_DLY - 1);
    localparam logic [T_W-1:0]    T_GAP     = T_W'(GAP_CYC - 1);

    sng_seq_state_t    r_state;
    sng_seq_state_t    w_state_nxt;
    logic              w_take;
    logic              w_abort;
    logic              w_tmr_load;
    logic [T_W-1:0]    w_tmr_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;

    logic              r_ready;
    logic              r_start;
    logic              r_stop;
    logic              r_bit_valid;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_done;
    logic              r_aborted;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic [X_W-1:0]    r_x_bn;

    assign w_take  = i_valid && (r_state == IDLE);
    assign w_abort = i_abort && (r_state inside {START, WAIT, STREAM});

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = START;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = T_PIPE;
                end
            end
            START: begin
                w_tmr_dec   = 1'b1;
                w_state_nxt = (PIPE_DLY == 1) ? STREAM : WAIT;
            end
            WAIT: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_zero) w_state_nxt = STREAM;
            end
            STREAM: begin
                if (r_bit_idx == IDX_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = GAP;
                w_tmr_load  = 1'b1;
                w_tmr_val   = T_GAP;
            end
            GAP: begin
                w_tmr_dec = 1'b1;
                if (w_tmr_zero) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort outranks the natural end of the stream.
        if (w_abort) begin
            w_state_nxt = GAP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = T_GAP;
        end
    end

    sng_seq_timer #(
        .CNT_W (T_W)
    ) u_timer (
        .i_clk_sng  (i_clk_sng),
        .i_rst_sng  (i_rst_sng),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Outputs are decoded from the next state so each one comes straight from a flop.
    always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
        if (i_rst_sng) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_idx   <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_frame_cnt <= '0;
            r_x_bn      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == IDLE);
            r_start     <= (w_state_nxt == START);
            r_bit_valid <= (w_state_nxt == STREAM);
            r_bit_idx   <= ((w_state_nxt == STREAM) && (r_state == STREAM)) ?
                           r_bit_idx + IDX_ONE : '0;
            r_done      <= (w_state_nxt == DONE) || w_abort;
            r_aborted   <= w_abort;
            r_stop      <= w_abort;
            if (w_state_nxt == DONE) r_frame_cnt <= r_frame_cnt + FCNT_ONE;
            if (w_take) r_x_bn <= i_x_vec;
        end
    end

    assign o_ready     = r_ready;
    assign o_start     = r_start;
    assign o_stop      = r_stop;
    assign o_bit_valid = r_bit_valid;
    assign o_bit_idx   = r_bit_idx;
    assign o_done      = r_done;
    assign o_aborted   = r_aborted;
    assign o_frame_cnt = r_frame_cnt;
    assign o_x_bn      = r_x_bn;

endmodule

// File: tb/tb_sng_bank_sequencer.sv
// Directed bench for sng_bank_sequencer: clean frames, back-to-back accepts,
// aborts, asynchronous reset and frame-counter wrap on a narrow-counter build.
module tb_sng_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] x_vec = '0;

    logic        ready, start, stop, bv, done, aborted;
    logic [31:0] x_bn;
    logic [3:0]  idx;
    logic [15:0] cnt;

    logic        valid4 = 1'b0;
    logic        ready4, start4, stop4, bv4, done4, aborted4;
    logic [31:0] x_bn4;
    logic [3:0]  idx4;
    logic [3:0]  cnt4;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sng_bank_sequencer u_dut (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_x_vec     (x_vec),
        .i_abort     (abort),
        .o_x_bn      (x_bn),
        .o_start     (start),
        .o_stop      (stop),
        .o_bit_valid (bv),
        .o_bit_idx   (idx),
        .o_done      (done),
        .o_aborted   (aborted),
        .o_frame_cnt (cnt)
    );

    sng_bank_sequencer #(
        .FCNT_W (4)
    ) u_dut4 (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst),
        .i_valid     (valid4),
        .o_ready     (ready4),
        .i_x_vec     (x_vec),
        .i_abort     (1'b0),
        .o_x_bn      (x_bn4),
        .o_start     (start4),
        .o_stop      (stop4),
        .o_bit_valid (bv4),
        .o_bit_idx   (idx4),
        .o_done      (done4),
        .o_aborted   (aborted4),
        .o_frame_cnt (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge it is idle again.
    task automatic run_frame(input logic [31:0] vec, input int exp_cnt);
        chk("f_idle_ready", ready, 1);
        valid = 1'b1;
        x_vec = vec;
        @(negedge clk);
        valid = 1'b0;
        x_vec = ~vec;
        chk("f_start", start, 1);
        chk("f_busy", ready, 0);
        chk("f_xbn", x_bn, vec);
        @(negedge clk);
        chk("f_wait_start", start, 0);
        chk("f_wait_bv", bv, 0);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("f_bv", bv, 1);
            chk("f_idx", idx, j);
            chk("f_hold", x_bn, vec);
        end
        @(negedge clk);
        chk("f_done", done, 1);
        chk("f_clean", aborted, 0);
        chk("f_bv_off", bv, 0);
        chk("f_cnt", cnt, exp_cnt);
        @(negedge clk);
        chk("f_gap_done", done, 0);
        chk("f_gap_ready", ready, 0);
        @(negedge clk);
        chk("f_back_idle", ready, 1);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_start", start, 0);
        chk("rst_bv", bv, 0);
        chk("rst_xbn", x_bn, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_stop", stop, 0);
        chk("idle_aborted", aborted, 0);
        chk("idle_idx", idx, 0);
        chk("idle_cnt", cnt, 0);

        // Clean frame, lanes 0..7
        run_frame(32'h7654_3210, 1);

        // Valid held high: accepts every 21 cycles
        valid = 1'b1;
        x_vec = 32'hA5A5_A5A5;
        for (int c = 0; c < 45; c++) begin
            chk("t2_ready", ready, (c % 21 == 0));
            chk("t2_start", start, (c % 21 == 1));
            if (c >= 1 && c <= 21) chk("t2_xa", x_bn, 32'hA5A5_A5A5);
            else if (c >= 22 && c <= 42) chk("t2_xb", x_bn, 32'h5A5A_5A5A);
            if (c == 1) x_vec = 32'h5A5A_5A5A;
            @(negedge clk);
        end
        valid = 1'b0;
        wait_ready("t2_drain");
        chk("t2_cnt", cnt, 4);

        // Abort at idx 5, then valid during GAP
        valid = 1'b1;
        x_vec = 32'hC3C3_C3C3;
        @(negedge clk);
        valid = 1'b0;
        x_vec = '0;
        repeat (7) @(negedge clk);
        chk("t3_idx5", idx, 5);
        chk("t3_bv", bv, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t3_stop", stop, 1);
        chk("t3_done", done, 1);
        chk("t3_aborted", aborted, 1);
        chk("t3_bv_off", bv, 0);
        chk("t3_idx0", idx, 0);
        chk("t3_cnt", cnt, 4);
        chk("t3_hold", x_bn, 32'hC3C3_C3C3);
        valid = 1'b1;
        x_vec = 32'hD2D2_D2D2;
        @(negedge clk);
        chk("t3_ready", ready, 1);
        chk("t3_no_start", start, 0);
        chk("t3_gap_ignored", x_bn, 32'hC3C3_C3C3);
        @(negedge clk);
        valid = 1'b0;
        chk("t3_restart", start, 1);
        chk("t3_xnew", x_bn, 32'hD2D2_D2D2);
        chk("t3_stop_off", stop, 0);

        // Abort on the last stream bit, then abort held through GAP and IDLE
        repeat (17) @(negedge clk);
        chk("t4_idx15", idx, 15);
        chk("t4_bv", bv, 1);
        abort = 1'b1;
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_aborted", aborted, 1);
        chk("t4_stop", stop, 1);
        chk("t4_bv_off", bv, 0);
        chk("t4_cnt", cnt, 4);
        @(negedge clk);
        chk("t4_gap_ready", ready, 1);
        chk("t4_gap_stop", stop, 0);
        chk("t4_gap_done", done, 0);
        @(negedge clk);
        chk("t4_idle_ready", ready, 1);
        chk("t4_idle_stop", stop, 0);
        chk("t4_idle_start", start, 0);
        abort = 1'b0;

        // Asynchronous reset mid-stream
        valid = 1'b1;
        x_vec = 32'hE1E1_E1E1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_bv_pre", bv, 1);
        chk("t5_idx_pre", idx, 3);
        #2 rst = 1'b1;
        #1;
        chk("t5_ready", ready, 1);
        chk("t5_bv", bv, 0);
        chk("t5_idx", idx, 0);
        chk("t5_xbn", x_bn, 0);
        chk("t5_cnt", cnt, 0);
        chk("t5_done", done, 0);
        @(negedge clk);
        chk("t5_no_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        run_frame(32'h7654_3210, 1);

        // Narrow counter wraps after 16 clean frames
        for (int f = 1; f <= 17; f++) begin
            for (int k = 0; k < 40 && ready4 !== 1'b1; k++) @(negedge clk);
            chk("t6_ready", ready4, 1);
            valid4 = 1'b1;
            @(negedge clk);
            valid4 = 1'b0;
            chk("t6_start", start4, 1);
            for (int k = 0; k < 40 && done4 !== 1'b1; k++) @(negedge clk);
            chk("t6_done", done4, 1);
            if (f == 16) chk("t6_cnt16", cnt4, 0);
            if (f == 17) chk("t6_cnt17", cnt4, 1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
